axi4_bridge_arbiter: RTL and testbench
======================================

Name: axi4_bridge_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single request port of the AXI4 bridge, sitting between the CPU fetch (m0) and data (m1) paths and the bridge.
- Grants round-robin and allows one outstanding transaction at a time.
- Holds off all grants until the PLL reports lock.
- Enforces a response timeout that returns an error to the requester and drains the late bridge response.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- TIMEOUT, 255, cycles allowed in WAIT_RSP before a timeout error; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pll_lock  in  1  PLL locked; no grant is issued while low
- m0_req_valid / m1_req_valid  in  1  request valid
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle
- m0_req_we / m1_req_we  in  1  1 = write
- m0_req_addr / m1_req_addr  in  ADDR_W  address
- m0_req_wdata / m1_req_wdata  in  DATA_W  write data
- m0_req_wstrb / m1_req_wstrb  in  DATA_W/8  byte strobes
- m0_rsp_valid / m1_rsp_valid  out  1  one-cycle response pulse
- m0_rsp_rdata / m1_rsp_rdata  out  DATA_W  read data
- m0_rsp_err / m1_rsp_err  out  1  bridge error or timeout
- br_req_valid  out  1  request to bridge
- br_req_ready  in  1  bridge accepts request
- br_req_we, br_req_addr, br_req_wdata, br_req_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- br_rsp_valid  in  1  bridge response
- br_rsp_rdata  in  DATA_W  bridge read data
- br_rsp_err  in  1  bridge error
- busy  out  1  state != IDLE
- timeout_cnt  out  8  saturating count of timeouts

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=1 (so m0 wins first), all valid/ready/err outputs 0, rdata and br_* fields 0, timeout_cnt 0, timer 0.
- States: IDLE, ISSUE, WAIT_RSP, FLUSH.
- IDLE, grant selection:
  - mX_req_ready is combinational: (state==IDLE) & pll_lock & rst==0 & winner==X.
  - Winner: the only valid requester; if both are valid, the one != last_grant.
- IDLE, on handshake: latch we/addr/wdata/wstrb into br_* and record owner. Next cycle: state=ISSUE, br_req_valid=1, last_grant=owner.
- ISSUE:
  - br_req_valid and the br_* fields are held stable until br_req_ready.
  - On br_req_ready: br_req_valid=0 next cycle, timer=0, state=WAIT_RSP.
  - ISSUE has no timeout.
- WAIT_RSP:
  - Timer increments each cycle.
  - On br_rsp_valid: next cycle the owner's rsp_valid=1 for exactly one cycle, with rsp_rdata=br_rsp_rdata and rsp_err=br_rsp_err; state=IDLE.
  - Otherwise, if TIMEOUT!=0 and timer==TIMEOUT-1: next cycle the owner's rsp_valid=1, rsp_err=1, rsp_rdata=0; timeout_cnt += 1, saturating at 255; state=FLUSH.
  - br_rsp_valid has priority over timeout in the same cycle.
- FLUSH: discard the next br_rsp_valid (no pulse to any requester), then go to IDLE. A br_rsp_valid arriving in the same cycle as the timeout decision is not a timeout.
- Response outputs: the non-owner's rsp_valid stays 0. rsp_rdata/rsp_err of both requesters hold their last value when rsp_valid=0.
- Latency: best case from req handshake to rsp_valid is 3 cycles (handshake, ISSUE with same-cycle ready, WAIT_RSP with same-cycle response). The earliest next grant is in the cycle rsp_valid is asserted.
- pll_lock dropping mid-transaction does not abort it; it only blocks new grants.
- rst mid-transaction: immediate return to reset values. Any later stray br_rsp_valid seen in IDLE is ignored.
- Unexpected br_rsp_valid in IDLE or ISSUE is ignored.

Test Plan:
- Lock gating: rst high 2 cycles, pll_lock=0, m0_req_valid=1 for 10 cycles -> m0_req_ready stays 0. pll_lock=1 -> m0_req_ready=1 that cycle. br_req_valid=1 one cycle later with addr=m0_req_addr.
- Single read, zero-wait bridge: m1 read addr=0x1000 with br_req_ready=1 and br_rsp_valid one cycle after acceptance, rdata=0xDEADBEEF_CAFEF00D -> m1_rsp_valid pulses once, 3 cycles after the handshake, with that rdata and err=0; m0_rsp_valid stays 0.
- Round-robin: m0 and m1 both continuously valid for 4 transactions -> grant order m0, m1, m0, m1. With only m0 valid -> m0 granted on every transaction.
- Backpressure: br_req_ready held 0 for 5 cycles during a write (wstrb=0x0F) -> br_req_valid and all br_* fields stable for 5 cycles; busy=1 throughout; no new grant.
- Timeout and flush: TIMEOUT=8, no response -> rsp_err=1 and rdata=0 on the owner 8 cycles after entering WAIT_RSP; timeout_cnt=1. A late br_rsp_valid is swallowed. The next request completes normally with err=0.
- Reset mid-WAIT_RSP: rst asserted -> all outputs return to reset values the next cycle. A subsequent stray br_rsp_valid produces no rsp_valid.

Source files
------------

// File: rtl/axi4_bridge_arbiter.sv
// Round-robin arbiter that serialises two requesters onto one bridge request port,
// with one transaction outstanding, PLL-lock gating and a response timeout.
module axi4_bridge_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_lock,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic                m0_req_we,
  input  logic [ADDR_W-1:0]   m0_req_addr,
  input  logic [DATA_W-1:0]   m0_req_wdata,
  input  logic [DATA_W/8-1:0] m0_req_wstrb,
  output logic                m0_rsp_valid,
  output logic [DATA_W-1:0]   m0_rsp_rdata,
  output logic                m0_rsp_err,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic                m1_req_we,
  input  logic [ADDR_W-1:0]   m1_req_addr,
  input  logic [DATA_W-1:0]   m1_req_wdata,
  input  logic [DATA_W/8-1:0] m1_req_wstrb,
  output logic                m1_rsp_valid,
  output logic [DATA_W-1:0]   m1_rsp_rdata,
  output logic                m1_rsp_err,
  output logic                br_req_valid,
  input  logic                br_req_ready,
  output logic                br_req_we,
  output logic [ADDR_W-1:0]   br_req_addr,
  output logic [DATA_W-1:0]   br_req_wdata,
  output logic [DATA_W/8-1:0] br_req_wstrb,
  input  logic                br_rsp_valid,
  input  logic [DATA_W-1:0]   br_rsp_rdata,
  input  logic                br_rsp_err,
  output logic                busy,
  output logic [7:0]          timeout_cnt
);
  localparam int TMR_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, FLUSH} state_t;

  state_t             state;
  logic               last_grant;
  logic               owner;
  logic [TMR_W-1:0]   timer;
  logic               winner;
  logic               grant;

  // On contention the requester that was not served last time wins.
  always_comb begin
    winner = (m0_req_valid && m1_req_valid) ? ~last_grant : m1_req_valid;
    grant  = (state == IDLE) && pll_lock && !rst && (m0_req_valid || m1_req_valid);
  end

  assign m0_req_ready = grant && !winner;
  assign m1_req_ready = grant && winner;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      timer        <= '0;
      timeout_cnt  <= '0;
      br_req_valid <= 1'b0;
      br_req_we    <= 1'b0;
      br_req_addr  <= '0;
      br_req_wdata <= '0;
      br_req_wstrb <= '0;
      m0_rsp_valid <= 1'b0;
      m0_rsp_rdata <= '0;
      m0_rsp_err   <= 1'b0;
      m1_rsp_valid <= 1'b0;
      m1_rsp_rdata <= '0;
      m1_rsp_err   <= 1'b0;
    end else begin
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner        <= winner;
            last_grant   <= winner;
            br_req_valid <= 1'b1;
            br_req_we    <= winner ? m1_req_we    : m0_req_we;
            br_req_addr  <= winner ? m1_req_addr  : m0_req_addr;
            br_req_wdata <= winner ? m1_req_wdata : m0_req_wdata;
            br_req_wstrb <= winner ? m1_req_wstrb : m0_req_wstrb;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (br_req_ready) begin
            br_req_valid <= 1'b0;
            timer        <= '0;
            state        <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          timer <= timer + TMR_W'(1);
          if (br_rsp_valid) begin
            if (owner) begin
              m1_rsp_valid <= 1'b1;
              m1_rsp_rdata <= br_rsp_rdata;
              m1_rsp_err   <= br_rsp_err;
            end else begin
              m0_rsp_valid <= 1'b1;
              m0_rsp_rdata <= br_rsp_rdata;
              m0_rsp_err   <= br_rsp_err;
            end
            state <= IDLE;
          end else if (TIMEOUT != 0 && timer == TMR_W'(TIMEOUT - 1)) begin
            if (owner) begin
              m1_rsp_valid <= 1'b1;
              m1_rsp_rdata <= '0;
              m1_rsp_err   <= 1'b1;
            end else begin
              m0_rsp_valid <= 1'b1;
              m0_rsp_rdata <= '0;
              m0_rsp_err   <= 1'b1;
            end
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state <= FLUSH;
          end
        end
        // The late bridge response still arrives; swallow it before re-arming.
        FLUSH: begin
          if (br_rsp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_bridge_arbiter.sv
// Randomised scoreboard bench: a bridge responder schedules expected responses,
// a negedge monitor checks grants, bridge requests and responses against them.
module tb_axi4_bridge_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, pll_lock;
  logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_err;
  logic [AW-1:0] m0_req_addr;
  logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
  logic [SW-1:0] m0_req_wstrb;
  logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_err;
  logic [AW-1:0] m1_req_addr;
  logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
  logic [SW-1:0] m1_req_wstrb;
  logic          br_req_valid, br_req_ready, br_req_we, br_rsp_valid, br_rsp_err;
  logic [AW-1:0] br_req_addr;
  logic [DW-1:0] br_req_wdata, br_rsp_rdata;
  logic [SW-1:0] br_req_wstrb;
  logic          busy;
  logic [7:0]    timeout_cnt;

  axi4_bridge_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .br_req_valid(br_req_valid), .br_req_ready(br_req_ready), .br_req_we(br_req_we),
    .br_req_addr(br_req_addr), .br_req_wdata(br_req_wdata), .br_req_wstrb(br_req_wstrb),
    .br_rsp_valid(br_rsp_valid), .br_rsp_rdata(br_rsp_rdata), .br_rsp_err(br_rsp_err),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] rdata;
    logic          err;
    bit            tmo;
  } rsp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  rsp_t rq0[$];
  rsp_t rq1[$];
  bit   own_q[$];
  int   free_q[$];
  int   cyc_cnt = 0;
  bit   no_rsp  = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- bridge responder ----------------
  initial begin : bridge
    int a, d, wt;
    bit own, late;
    logic [DW-1:0] rd;
    logic er;
    rsp_t e;
    br_req_ready = 1'b0; br_rsp_valid = 1'b0; br_rsp_rdata = '0; br_rsp_err = 1'b0;
    wt = 0;
    forever begin
      @(posedge clk); #1;
      br_rsp_valid = ($urandom_range(0, 9) == 0);  // stray pulse, arbiter not waiting
      br_rsp_rdata = {$urandom, $urandom};
      br_rsp_err   = 1'($urandom_range(0, 1));
      br_req_ready = no_rsp || (wt >= 5) || ($urandom_range(0, 2) == 0);
      @(negedge clk);
      wt = br_req_valid ? wt + 1 : 0;
      if (br_req_valid && br_req_ready) begin
        wt  = 0;
        a   = cyc_cnt;
        own = (own_q.size() > 0) ? own_q.pop_front() : 1'b0;
        @(posedge clk); #1;
        br_req_ready = 1'b0;
        br_rsp_valid = 1'b0;
        if (no_rsp) begin
          repeat (12) begin @(posedge clk); #1; end
          br_rsp_valid = 1'b1;
          @(posedge clk); #1;
          br_rsp_valid = 1'b0;
        end else begin
          late = ($urandom_range(0, 4) == 0);
          d    = late ? TMO + int'($urandom_range(0, 3)) : int'($urandom_range(0, TMO - 1));
          rd   = {$urandom, $urandom};
          er   = ($urandom_range(0, 3) == 0);
          if (late) begin
            e.cyc = a + 1 + TMO; e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1;
          end else begin
            e.cyc = a + 2 + d;   e.rdata = rd; e.err = er;   e.tmo = 1'b0;
          end
          if (own) rq1.push_back(e); else rq0.push_back(e);
          free_q.push_back(a + 2 + d);
          repeat (d) begin @(posedge clk); #1; end
          br_rsp_valid = 1'b1;
          br_rsp_rdata = rd;
          br_rsp_err   = er;
          @(posedge clk); #1;
          br_rsp_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit            lg = 1'b1, issuing = 1'b0, prev_rst = 1'b1, wait_free = 1'b0;
  int            free_at = 0, tcnt = 0;
  logic [DW-1:0] last_rd[2];
  logic          last_err[2];
  req_t          cur;
  bit            idle, win, any, have, pop;
  rsp_t          h;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_cnt, act, exp);
    end
  endtask

  task automatic chk_rsp(input int x, input logic v, input logic [DW-1:0] rd, input logic er,
                         input bit hv, input rsp_t hd, output bit pp);
    pp = 1'b0;
    if (v) begin
      if (!hv) begin
        chk($sformatf("m%0d_rsp_unexpected", x), 64'(v), 64'(0));
      end else begin
        pp = 1'b1;
        $display("rsp m%0d cyc=%0d rdata=%h err=%b tmo=%0d", x, cyc_cnt, rd, er, hd.tmo);
        chk($sformatf("m%0d_rsp_cycle", x), 64'(cyc_cnt), 64'(hd.cyc));
        chk($sformatf("m%0d_rsp_rdata", x), 64'(rd), 64'(hd.rdata));
        chk($sformatf("m%0d_rsp_err", x), 64'(er), 64'(hd.err));
        last_rd[x]  = hd.rdata;
        last_err[x] = hd.err;
        if (hd.tmo) begin
          if (tcnt < 255) tcnt++;
          chk("timeout_cnt", 64'(timeout_cnt), 64'(tcnt));
        end
      end
    end else begin
      if (hv && hd.cyc < cyc_cnt) begin
        chk($sformatf("m%0d_rsp_missing", x), 64'(v), 64'(1));
        pp = 1'b1;
      end
      chk($sformatf("m%0d_rdata_hold", x), 64'(rd), 64'(last_rd[x]));
      chk($sformatf("m%0d_err_hold", x), 64'(er), 64'(last_err[x]));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      lg = 1'b1; issuing = 1'b0; free_at = 0; wait_free = 1'b0; tcnt = 0;
      last_rd[0] = '0; last_rd[1] = '0; last_err[0] = 1'b0; last_err[1] = 1'b0;
      rq0.delete(); rq1.delete(); own_q.delete(); free_q.delete();
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_br_valid", 64'(br_req_valid), 64'(0));
        chk("rst_br_we", 64'(br_req_we), 64'(0));
        chk("rst_br_addr", 64'(br_req_addr), 64'(0));
        chk("rst_br_wdata", 64'(br_req_wdata), 64'(0));
        chk("rst_br_wstrb", 64'(br_req_wstrb), 64'(0));
        chk("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
        chk("rst_m0_rsp_valid", 64'(m0_rsp_valid), 64'(0));
        chk("rst_m1_rsp_valid", 64'(m1_rsp_valid), 64'(0));
      end
      prev_rst = 1'b0;
      if (wait_free && free_q.size() > 0) begin
        free_at   = free_q.pop_front();
        wait_free = 1'b0;
      end
      idle = !wait_free && (cyc_cnt >= free_at);
      chk("busy", 64'(busy), 64'(!idle));

      have = (rq0.size() > 0);
      if (have) h = rq0[0];
      chk_rsp(0, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err, have, h, pop);
      if (pop) void'(rq0.pop_front());
      have = (rq1.size() > 0);
      if (have) h = rq1[0];
      chk_rsp(1, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err, have, h, pop);
      if (pop) void'(rq1.pop_front());

      chk("br_req_valid", 64'(br_req_valid), 64'(issuing));
      if (br_req_valid) begin
        chk("br_we", 64'(br_req_we), 64'(cur.we));
        chk("br_addr", 64'(br_req_addr), 64'(cur.addr));
        chk("br_wdata", 64'(br_req_wdata), 64'(cur.wdata));
        chk("br_wstrb", 64'(br_req_wstrb), 64'(cur.wstrb));
        if (br_req_ready) issuing = 1'b0;
      end

      // Grant rule: sole valid requester, else the one not served last.
      win = (m0_req_valid && m1_req_valid) ? !lg : m1_req_valid;
      any = idle && pll_lock && (m0_req_valid || m1_req_valid);
      chk("m0_req_ready", 64'(m0_req_ready), 64'(any && !win));
      chk("m1_req_ready", 64'(m1_req_ready), 64'(any && win));
      if (any) begin
        if (win) cur = '{m1_req_we, m1_req_addr, m1_req_wdata, m1_req_wstrb};
        else     cur = '{m0_req_we, m0_req_addr, m0_req_wdata, m0_req_wstrb};
        lg        = win;
        issuing   = 1'b1;
        wait_free = 1'b1;
        own_q.push_back(win);
      end
    end
  end

  // ---------------- requester stimulus ----------------
  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic rand_req(input int pv);
    m0_req_valid = ($urandom_range(0, 99) < pv);
    m1_req_valid = ($urandom_range(0, 99) < pv);
    m0_req_we = 1'($urandom_range(0, 1)); m1_req_we = 1'($urandom_range(0, 1));
    m0_req_addr = $urandom; m1_req_addr = $urandom;
    m0_req_wdata = {$urandom, $urandom}; m1_req_wdata = {$urandom, $urandom};
    m0_req_wstrb = 8'($urandom); m1_req_wstrb = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0;
    m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_wstrb = '0;
    m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_wstrb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // no grant while the PLL is unlocked, then immediate grant on lock
    m0_req_valid = 1'b1; m0_req_addr = 32'h0000_1000; m0_req_we = 1'b1;
    m0_req_wdata = 64'hDEAD_BEEF_CAFE_F00D; m0_req_wstrb = 8'h0F;
    repeat (10) step();
    pll_lock = 1'b1;
    step();
    m0_req_valid = 1'b0;
    repeat (30) step();

    repeat (600) begin
      rand_req(60);
      pll_lock = ($urandom_range(0, 9) != 0);
      step();
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; pll_lock = 1'b1;
    repeat (40) step();

    // reset while waiting for a response, then a stray late bridge response
    no_rsp = 1'b1;
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 32'h0000_2000;
    step();
    m0_req_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) step();
    no_rsp = 1'b0;

    repeat (150) begin
      rand_req(40);
      pll_lock = 1'b1;
      step();
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (40) step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
